bcd_to_binary: RTL and testbench

Sequential reverse double-dabble converter that turns a packed multi-digit BCD value into its unsigned binary equivalent. It is the inverse of the display path's binary-to-BCD stage. It sits between digit-oriented sources (score entry, BCD counters, digit registers) and binary arithmetic such as high-score compare and game-speed scaling. Conversion is iterative, one bit per clock, with a start/busy/done handshake.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bcd_to_binary.sv | 135 +++++++++++++
 tb/tb_bcd_to_binary.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD conversion definitions: FSM states, digit constants and width helper.
// Used by both the BCD-to-binary and the display-side binary-to-BCD stages.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_MAX  = 9;
  localparam int unsigned BCD_ADJ_THRESH = 8;
  localparam int unsigned BCD_ADJ        = 3;

  // Smallest binary width able to hold 10^digits - 1.
  function automatic int unsigned bcd_min_width(input int unsigned digits);
    longint unsigned max_val;
    int unsigned     w;
    max_val = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    w = 0;
    while ((64'd1 << w) <= max_val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: digits of 8 or more drop by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit_c
);

  assign o_digit_c = (i_digit >= 4'(BCD_ADJ_THRESH)) ? i_digit - 4'(BCD_ADJ) : i_digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative packed-BCD to unsigned binary converter, one result bit per clock,
// with a start/busy/done handshake and invalid-digit detection.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  bcd_state_e         r_state;
  logic [BCD_W-1:0]   r_digits;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;

  bcd_state_e         w_state_nxt;
  logic [BCD_W-1:0]   w_digits_nxt;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_binary_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;

  logic [BCD_W+WIDTH-1:0] w_shifted;
  logic [BCD_W-1:0]       w_shift_digits;
  logic [WIDTH-1:0]       w_shift_acc;
  logic [BCD_W-1:0]       w_adj_digits;
  logic [DIGITS-1:0]      w_bad;
  logic                   w_any_bad;

  // Digits and accumulator shift as one long register; the lowest digit feeds the accumulator MSB.
  assign w_shifted      = {r_digits, r_acc} >> 1;
  assign w_shift_digits = w_shifted[BCD_W+WIDTH-1:WIDTH];
  assign w_shift_acc    = w_shifted[WIDTH-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_adjust u_adj (
      .i_digit   (w_shift_digits[4*d +: 4]),
      .o_digit_c (w_adj_digits[4*d +: 4])
    );
    assign w_bad[d] = (bcd[4*d +: 4] > 4'(BCD_DIGIT_MAX));
  end

  assign w_any_bad = |w_bad;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      binary   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      binary   <= w_binary_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      error    <= w_error_nxt;
    end
  end

  // Next-state and next-output logic; FINISH accepts start like IDLE for back-to-back use.
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_binary_nxt = binary;
    w_busy_nxt   = busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = error;

    case (r_state)
      IDLE, FINISH: begin
        if (r_state == FINISH) begin
          w_state_nxt = IDLE;
        end
        if (start) begin
          w_digits_nxt = bcd;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          if (w_any_bad) begin
            w_error_nxt  = 1'b1;
            w_binary_nxt = '0;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = FINISH;
          end else begin
            w_error_nxt  = 1'b0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = SHIFT;
          end
        end
      end

      SHIFT: begin
        w_digits_nxt = w_adj_digits;
        w_acc_nxt    = w_shift_acc;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_binary_nxt = w_shift_acc;
          w_error_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = FINISH;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and exhaustive checks for bcd_to_binary at DIGITS=3, WIDTH=10.
module tb_bcd_to_binary;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned WIDTH  = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [11:0]       bcd;
  logic [WIDTH-1:0]  binary;
  logic              busy;
  logic              done;
  logic              error;

  int n_checks;
  int n_errors;

  bcd_to_binary #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd    (bcd),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion in the current cycle; return positioned in the done cycle.
  task automatic do_conv(input string tag, input logic [11:0] code, input logic [9:0] exp_bin,
                         input logic exp_err, input int exp_lat, input logic [9:0] prev_bin);
    int lat;
    bit got_done;
    bit busy_bad;
    bit stable_bad;
    bcd   = code;
    start = 1'b1;
    tick();
    start      = 1'b0;
    lat        = 1;
    got_done   = 1'b0;
    busy_bad   = 1'b0;
    stable_bad = 1'b0;
    while (lat <= 20 && !got_done) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (binary !== prev_bin) stable_bad = 1'b1;
        lat++;
        tick();
      end
    end
    check({tag, " done seen"}, 32'(got_done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " binary"}, 32'(binary), 32'(exp_bin));
    check({tag, " error"}, 32'(error), 32'(exp_err));
    check({tag, " busy/done"}, 32'(busy | busy_bad | stable_bad), 32'd0);
  endtask

  initial begin
    int seen;
    int cyc;
    logic [9:0] last;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 12'h000;

    // Reset state.
    repeat (3) tick();
    check("reset binary", 32'(binary), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic valid conversions.
    do_conv("c999", 12'h999, 10'd999, 1'b0, 11, 10'd0);
    tick();
    check("c999 single pulse", 32'(done), 32'd0);
    do_conv("c255", 12'h255, 10'd255, 1'b0, 11, 10'd999);
    tick();
    do_conv("c000", 12'h000, 10'd0, 1'b0, 11, 10'd255);
    tick();
    do_conv("c010", 12'h010, 10'd10, 1'b0, 11, 10'd0);
    tick();

    // Invalid digit.
    do_conv("c1A3", 12'h1A3, 10'd0, 1'b1, 1, 10'd10);
    tick();
    check("c1A3 error held", 32'(error), 32'd1);
    check("c1A3 no busy", 32'(busy), 32'd0);
    check("c1A3 single pulse", 32'(done), 32'd0);
    tick();

    // Start while busy is ignored; bcd changes after accept have no effect.
    bcd   = 12'h123;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bcd   = 12'h456;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 6;
    while (cyc < 30 && done !== 1'b1) begin
      cyc++;
      tick();
    end
    check("ignore latency", 32'(cyc), 32'd11);
    check("ignore binary", 32'(binary), 32'd123);
    seen = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("ignore no second done", 32'(seen), 32'd0);

    // Back-to-back: second start in the done cycle.
    do_conv("b2b 042", 12'h042, 10'd42, 1'b0, 11, 10'd123);
    do_conv("b2b 777", 12'h777, 10'd777, 1'b0, 11, 10'd42);
    tick();
    check("b2b single pulse", 32'(done), 32'd0);
    tick();

    // Reset mid-conversion aborts with no done.
    bcd   = 12'h500;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort binary", 32'(binary), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort error", 32'(error), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);
    do_conv("abort restart", 12'h500, 10'd500, 1'b0, 11, 10'd0);

    // Exhaustive sweep, back-to-back.
    last = 10'd500;
    for (int h = 0; h < 10; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int u = 0; u < 10; u++) begin
          logic [11:0] code;
          logic [9:0]  exp_v;
          code  = {4'(h), 4'(t), 4'(u)};
          exp_v = 10'(h * 100 + t * 10 + u);
          do_conv($sformatf("sweep %03h", code), code, exp_v, 1'b0, 11, last);
          last = exp_v;
        end
      end
    end
    tick();
    check("sweep final idle", 32'(done | busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
